// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: ROM port, decoder feedback (GOTO, status) and the
// instruction register outputs that feed the decoder.
interface fetch_sequencer_if #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumStatusBits     = 3
);
  logic [PC_WIDTH-1:0]          prog_adr;
  logic                         prog_rd_en;
  logic [PROGRAM_DataWidth-1:0] prog_data;
  logic                         cnt_wr_en;
  logic [7:0]                   literal_adr;
  logic [NumStatusBits-1:0]     status;
  logic [PROGRAM_DataWidth-1:0] instruction;
  logic                         instr_valid;
  logic [PC_WIDTH-1:0]          pc;
  logic                         skip_active;

  modport master (
    output prog_adr, prog_rd_en, instruction, instr_valid, pc, skip_active,
    input  prog_data, cnt_wr_en, literal_adr, status
  );

  modport slave (
    input  prog_adr, prog_rd_en, instruction, instr_valid, pc, skip_active,
    output prog_data, cnt_wr_en, literal_adr, status
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter, ROM fetch and instruction register with conditional-skip
// evaluation; three clocks per instruction.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_FETCH | ROM address = pc, read strobe = run_en; stall here if idle
//   S_WAIT  | ROM data valid, latched into instruction register at edge
//   S_EXEC  | decoder outputs valid; pc and skip flag update at edge
module fetch_sequencer #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int NumStatusBits     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_en_i,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  localparam logic [NumOpCodeBits-1:0] OP_IFZ  = NumOpCodeBits'(5'b10001);
  localparam logic [NumOpCodeBits-1:0] OP_IFNZ = NumOpCodeBits'(5'b10010);
  localparam logic [NumOpCodeBits-1:0] OP_IFEQ = NumOpCodeBits'(5'b10011);
  localparam logic [NumOpCodeBits-1:0] OP_IFST = NumOpCodeBits'(5'b10100);
  localparam logic [NumOpCodeBits-1:0] OP_IFGT = NumOpCodeBits'(5'b10101);

  state_t                       state_q;
  logic [PC_WIDTH-1:0]          pc_q, pc_d;
  logic [PROGRAM_DataWidth-1:0] instr_q;
  logic                         instr_valid_q;
  logic                         skip_q, skip_d;

  logic [NumOpCodeBits-1:0]     opcode;
  logic                         is_if;
  logic                         cond_pass;
  logic                         flag_z, flag_c;
  logic                         unused_status_n;

  assign opcode          = instr_q[PROGRAM_DataWidth-1 -: NumOpCodeBits];
  assign flag_z          = bus.status[0];
  assign flag_c          = bus.status[1];
  assign unused_status_n = bus.status[2];

  always_comb begin
    is_if     = 1'b1;
    cond_pass = 1'b1;
    case (opcode)
      OP_IFZ, OP_IFEQ: cond_pass = flag_z;
      OP_IFNZ:         cond_pass = ~flag_z;
      OP_IFST:         cond_pass = flag_c;
      OP_IFGT:         cond_pass = ~flag_z & ~flag_c;
      default:         is_if     = 1'b0;
    endcase
  end

  // A discarded word (instr_valid low in EXEC) always clears the skip flag,
  // so a skipped IF or GOTO has no effect beyond the pc increment.
  always_comb begin
    if (instr_valid_q && bus.cnt_wr_en) begin
      pc_d = bus.literal_adr[PC_WIDTH-1:0];
    end else begin
      pc_d = pc_q + PC_WIDTH'(1);
    end
    skip_d = instr_valid_q & is_if & ~cond_pass;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      skip_q        <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (run_en_i) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          instr_q       <= bus.prog_data;
          instr_valid_q <= ~skip_q;
          state_q       <= S_EXEC;
        end
        S_EXEC: begin
          instr_valid_q <= 1'b0;
          pc_q          <= pc_d;
          skip_q        <= skip_d;
          state_q       <= S_FETCH;
        end
        default: begin
          state_q       <= S_FETCH;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Read strobe is combinational on run_en and forced low while in reset.
  assign bus.prog_rd_en  = rst_n & run_en_i & (state_q == S_FETCH);
  assign bus.prog_adr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.skip_active = skip_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: ROM and decoder stand-ins, an instruction-level
// reference model, directed vectors and randomized programs.
module tb_fetch_sequencer;

  localparam logic [4:0] OP_GOTO = 5'b01100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run_en = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [15:0] rom [256];
  int  m_pc;
  bit  m_skip;
  logic last_valid;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_en_i (run_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.prog_rd_en) bus.prog_data <= rom[bus.prog_adr];
  end

  // Decoder stand-in: recognises GOTO regardless of instr_valid.
  assign bus.cnt_wr_en   = (bus.instruction[15:11] == OP_GOTO);
  assign bus.literal_adr = bus.instruction[7:0];

  typedef struct {
    logic [4:0] op;
    logic [2:0] st;
    bit         exp_skip;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit if_fails(input logic [4:0] op, input logic [2:0] st);
    case (op)
      5'b10001, 5'b10011: return !st[0];
      5'b10010:           return st[0];
      5'b10100:           return !st[1];
      5'b10101:           return st[0] | st[1];
      default:            return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    run_en = 1'b1;
    #1;
    chk("rst_instr_valid", bus.instr_valid, 1'b0);
    chk("rst_pc", bus.pc, 8'h00);
    chk("rst_skip", bus.skip_active, 1'b0);
    chk("rst_instruction", bus.instruction, 16'h0000);
    chk("rst_rd_en", bus.prog_rd_en, 1'b0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    m_pc   = 0;
    m_skip = 1'b0;
  endtask

  // One instruction: fetch, wait, exec. Optional stall drops run_en in WAIT.
  task automatic step_x(input logic [2:0] st, input int stall);
    logic [15:0] w;
    bit ok, ex;
    ok = 1'b0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (bus.prog_rd_en) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("fetch_timeout", 1'b0, 1'b1);
      return;
    end
    bus.status = st;
    chk("prog_adr", bus.prog_adr, m_pc[7:0]);
    chk("pc", bus.pc, m_pc[7:0]);
    chk("skip_active", bus.skip_active, m_skip);
    chk("valid_in_fetch", bus.instr_valid, 1'b0);
    w  = rom[m_pc];
    ex = !m_skip;
    @(negedge clk);
    if (stall > 0) run_en = 1'b0;
    chk("valid_in_wait", bus.instr_valid, 1'b0);
    @(negedge clk);
    chk("instruction", bus.instruction, w);
    chk("instr_valid", bus.instr_valid, ex);
    last_valid = bus.instr_valid;
    if (ex && w[15:11] == OP_GOTO) m_pc = int'(w[7:0]);
    else m_pc = (m_pc + 1) % 256;
    m_skip = ex && if_fails(w[15:11], st);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_rd_en", bus.prog_rd_en, 1'b0);
      chk("stall_pc", bus.pc, m_pc[7:0]);
      chk("stall_skip", bus.skip_active, m_skip);
      chk("stall_valid", bus.instr_valid, 1'b0);
    end
    run_en = 1'b1;
  endtask

  task automatic step(input logic [2:0] st);
    step_x(st, 0);
  endtask

  vec_t vecs [13];

  initial begin
    bus.status = 3'b000;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;

    vecs[0]  = '{5'b10001, 3'b000, 1'b1};
    vecs[1]  = '{5'b10001, 3'b001, 1'b0};
    vecs[2]  = '{5'b10010, 3'b001, 1'b1};
    vecs[3]  = '{5'b10010, 3'b110, 1'b0};
    vecs[4]  = '{5'b10011, 3'b001, 1'b0};
    vecs[5]  = '{5'b10011, 3'b010, 1'b1};
    vecs[6]  = '{5'b10100, 3'b010, 1'b0};
    vecs[7]  = '{5'b10100, 3'b101, 1'b1};
    vecs[8]  = '{5'b10101, 3'b100, 1'b0};
    vecs[9]  = '{5'b10101, 3'b010, 1'b1};
    vecs[10] = '{5'b10101, 3'b001, 1'b1};
    vecs[11] = '{5'b11111, 3'b000, 1'b0};
    vecs[12] = '{5'b00000, 3'b000, 1'b0};

    // Straight-line fetch, GOTO, skipped GOTO, stall with skip pending, wrap.
    rom[8'h00] = 16'h0000;
    rom[8'h01] = 16'h0855;
    rom[8'h02] = 16'h1234;
    rom[8'h03] = 16'h6010;
    rom[8'h10] = 16'h8800;
    rom[8'h11] = 16'h6080;
    rom[8'h12] = 16'h60FF;
    rom[8'hFF] = 16'h0000;
    do_reset();
    step(3'b000);
    step(3'b000);
    step(3'b000);
    step(3'b000);
    step_x(3'b000, 2);
    step(3'b000);
    step(3'b000);
    step_x(3'b000, 3);
    step(3'b000);
    chk("wrap_exec_valid", last_valid, 1'b1);

    // Conditional-skip vectors.
    foreach (vecs[i]) begin
      do_reset();
      rom[0] = {vecs[i].op, 11'h000};
      rom[1] = 16'h6ABC;
      rom[2] = 16'h0000;
      step(vecs[i].st);
      @(negedge clk);
      chk("tbl_skip", bus.skip_active, vecs[i].exp_skip);
      step(3'b000);
      chk("tbl_exec", last_valid, !vecs[i].exp_skip);
      step(3'b000);
    end

    // Reset during EXEC of GOTO 0x40 discards it; next fetch from 0.
    do_reset();
    rom[0] = 16'h0000;
    rom[1] = 16'h6040;
    step(3'b000);
    @(negedge clk);
    chk("rx_fetch_adr", bus.prog_adr, 8'h01);
    @(negedge clk);
    @(negedge clk);
    chk("rx_exec_valid", bus.instr_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rx_valid_async", bus.instr_valid, 1'b0);
    chk("rx_pc_async", bus.pc, 8'h00);
    chk("rx_rd_en", bus.prog_rd_en, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_pc   = 0;
    m_skip = 1'b0;
    step(3'b000);

    // Pending skip is cleared by reset.
    do_reset();
    rom[0] = 16'h8800;
    step(3'b000);
    @(negedge clk);
    chk("rs_skip_set", bus.skip_active, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rs_skip_clr", bus.skip_active, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_pc   = 0;
    m_skip = 1'b0;
    step(3'b000);

    // Randomized programs biased toward IFs and GOTOs.
    for (int a = 0; a < 256; a++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rom[a] = {5'(5'b10001 + $urandom_range(0, 4)), 11'($urandom)};
        4, 5:       rom[a] = {OP_GOTO, 3'($urandom), 8'($urandom)};
        default:    rom[a] = 16'($urandom);
      endcase
    end
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step_x(3'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
